// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, WIDTH data bits LSB first, parity, stop.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the last three ticks.
module uart_rx #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  input  logic             rx_line,
  input  logic             parity_even_n,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_busy,
  output logic             parity_err,
  output logic             frame_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(WIDTH) + 1;
  localparam logic [TW-1:0] HalfM1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FullM1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LastBit = BW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q;
  logic [TW-1:0]     tick_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [WIDTH-1:0]  shift_q;
  logic              par_q;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic              bit_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_line};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds the sample from the previous tick, hist_q[1] the one before.
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (!rst_n)           hist_q <= 2'b11;
    else if (sample_tick) hist_q <= {hist_q[0], rx_s};
  end
  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_busy    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q    <= StStart;
              tick_cnt_q <= '0;
              rx_busy    <= 1'b1;
            end
          end
          StStart: begin
            if (tick_cnt_q == HalfM1) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              if (bit_s) begin
                // Line went back high before mid-start: glitch, not a frame.
                state_q <= StIdle;
                rx_busy <= 1'b0;
              end else begin
                state_q <= StData;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          StData: begin
            if (tick_cnt_q == FullM1) begin
              shift_q    <= {bit_s, shift_q[WIDTH-1:1]};
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == LastBit) state_q <= StParity;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          StParity: begin
            if (tick_cnt_q == FullM1) begin
              par_q      <= bit_s;
              tick_cnt_q <= '0;
              state_q    <= StStop;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          StStop: begin
            if (tick_cnt_q == FullM1) begin
              rx_data    <= shift_q;
              parity_err <= ((^shift_q) ^ parity_even_n) != par_q;
              frame_err  <= !bit_s;
              rx_valid   <= 1'b1;
              rx_busy    <= 1'b0;
              tick_cnt_q <= '0;
              state_q    <= StIdle;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (WIDTH=32, OVERSAMPLE=16, tick every 4 clocks).
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int W    = 32;
  localparam int TDIV = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_tick = 1'b0;
  logic         rx_line = 1'b1;
  logic         parity_even_n = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_busy;
  logic         parity_err;
  logic         frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int dbl_cnt   = 0;
  int busy_drop = 0;
  int busy_cnt  = 0;
  int div = 0;
  logic prev_valid = 1'b0;
  logic chk_busy = 1'b0;

  uart_rx #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .rx_line       (rx_line),
    .parity_even_n (parity_even_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .parity_err    (parity_err),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Tick strobe changes on the falling edge so it is stable at the rising edge.
  always @(negedge clk) begin
    div = (div + 1) % TDIV;
    sample_tick = (div == 0);
  end

  always @(negedge clk) begin
    if (rx_valid) valid_cnt++;
    if (rx_valid && prev_valid) dbl_cnt++;
    prev_valid = rx_valid;
    if (chk_busy && !rx_busy) busy_drop++;
    if (rx_busy) busy_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout, expected $finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!sample_tick);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    for (int t = 0; t < OS; t++) begin
      rx_line = b ^ (glitch && (t == OS / 2));
      wait_tick();
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stp,
                            input int gbit);
    send_bit(1'b0, 1'b0);
    chk_busy = 1'b1;
    for (int i = 0; i < W; i++) send_bit(d[i], i == gbit);
    send_bit(par, 1'b0);
    chk_busy = 1'b0;
    send_bit(stp, 1'b0);
    rx_line = 1'b1;
    repeat (4) wait_tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},  64'(rx_data), 64'h0);
    check({tag, "_valid"}, 64'(rx_valid), 64'h0);
    check({tag, "_busy"},  64'(rx_busy), 64'h0);
    check({tag, "_perr"},  64'(parity_err), 64'h0);
    check({tag, "_ferr"},  64'(frame_err), 64'h0);
  endtask

  initial begin
    int v0;
    int b0;
    logic [W-1:0] exp_glitch;
    logic         exp_glitch_perr;

    repeat (5) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (4) wait_tick();

    // Even parity frame
    v0 = valid_cnt; b0 = busy_drop;
    send_frame(32'hA5A5_5A5A, 1'b0, 1'b1, -1);
    check("even_valid", 64'(valid_cnt - v0), 64'd1);
    check("even_data", 64'(rx_data), 64'hA5A5_5A5A);
    check("even_perr", 64'(parity_err), 64'h0);
    check("even_ferr", 64'(frame_err), 64'h0);
    check("even_busy_held", 64'(busy_drop - b0), 64'h0);
    check("even_busy_end", 64'(rx_busy), 64'h0);

    // Odd parity: good then bad parity bit
    parity_even_n = 1'b1;
    send_frame(32'h0000_0001, 1'b0, 1'b1, -1);
    check("odd_data", 64'(rx_data), 64'h1);
    check("odd_perr", 64'(parity_err), 64'h0);
    v0 = valid_cnt;
    send_frame(32'h0000_0001, 1'b1, 1'b1, -1);
    check("odd_bad_valid", 64'(valid_cnt - v0), 64'd1);
    check("odd_bad_data", 64'(rx_data), 64'h1);
    check("odd_bad_perr", 64'(parity_err), 64'h1);

    // Framing error, then a clean frame after one idle bit
    parity_even_n = 1'b0;
    v0 = valid_cnt;
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    check("ferr_valid", 64'(valid_cnt - v0), 64'd1);
    check("ferr_flag", 64'(frame_err), 64'h1);
    check("ferr_data", 64'(rx_data), 64'hFFFF_FFFF);
    check("ferr_perr", 64'(parity_err), 64'h0);
    repeat (OS) wait_tick();
    v0 = valid_cnt;
    send_frame(32'h1234_5678, 1'b1, 1'b1, -1);
    check("clean_valid", 64'(valid_cnt - v0), 64'd1);
    check("clean_data", 64'(rx_data), 64'h1234_5678);
    check("clean_ferr", 64'(frame_err), 64'h0);
    check("clean_perr", 64'(parity_err), 64'h0);

    // False start: 3-tick low pulse
    v0 = valid_cnt; b0 = busy_cnt;
    rx_line = 1'b0;
    repeat (3) wait_tick();
    rx_line = 1'b1;
    repeat (OS / 2) wait_tick();
    check("false_busy_seen", 64'(busy_cnt > b0), 64'h1);
    check("false_busy_drop", 64'(rx_busy), 64'h0);
    repeat (OS) wait_tick();
    check("false_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("false_data_kept", 64'(rx_data), 64'h1234_5678);

    // Reset after 10 data bits; reset pulse lands on a tick cycle
    v0 = valid_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'(32'hDEAD_BEEF >> i), 1'b0);
    repeat (TDIV - 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    rx_line = 1'b1;
    repeat (OS * 25) wait_tick();
    check("midreset_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("midreset_idle", 64'(rx_busy), 64'h0);
    send_frame(32'hCAFE_F00D, 1'b0, 1'b1, -1);
    check("after_reset_valid", 64'(valid_cnt - v0), 64'd1);
    check("after_reset_data", 64'(rx_data), 64'hCAFE_F00D);
    check("after_reset_perr", 64'(parity_err), 64'h0);
    check("after_reset_ferr", 64'(frame_err), 64'h0);

    // One-tick glitch at the centre of data bit 5
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 32'h0000_0000;
    exp_glitch_perr = 1'b0;
`else
    exp_glitch = 32'h0000_0020;
    exp_glitch_perr = 1'b1;
`endif
    v0 = valid_cnt;
    send_frame(32'h0000_0000, 1'b0, 1'b1, 5);
    check("glitch_valid", 64'(valid_cnt - v0), 64'd1);
    check("glitch_data", 64'(rx_data), 64'(exp_glitch));
    check("glitch_perr", 64'(parity_err), 64'(exp_glitch_perr));

    check("valid_one_cycle", 64'(dbl_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the TX serial line: start bit (0), WIDTH data bits LSB first, one parity bit, one stop bit (1).
- Oversamples the line with a strobe running OVERSAMPLE times the baud rate. Samples at bit centres, rebuilds the parallel word, and reports parity and framing errors.
- Sits directly downstream of the transmitter (loopback or remote link) and feeds the host-side consumer with a 1-cycle valid pulse.

Parameters:
- WIDTH, 32, data bits per frame.
- OVERSAMPLE, 16, sample_tick pulses per bit period. Must be even and at least 4; at least 8 when UART_RX_MAJORITY_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- sample_tick  input  1  oversample strobe, 1 clk wide, OVERSAMPLE x baud
- rx_line  input  1  asynchronous serial input, idle high
- parity_even_n  input  1  parity mode (0=even, 1=odd); expected parity = (^data) ^ parity_even_n
- rx_data  output  WIDTH  last received word; holds until the next frame completes
- rx_valid  output  1  1-cycle pulse when rx_data/parity_err/frame_err are updated
- rx_busy  output  1  high while a frame is in progress
- parity_err  output  1  parity mismatch on the last frame; held until the next frame completes
- frame_err  output  1  stop bit sampled 0 on the last frame; held until the next frame completes

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low, sampled on the rising edge of clk. While rst_n=0:
  - state=IDLE, all counters 0.
  - rx_data=0, rx_valid=0, rx_busy=0, parity_err=0, frame_err=0.
  - Both synchroniser flops set to 1.
- Input sync: rx_line passes through 2 flops (rx_s). All decisions use rx_s.
- Counters advance only on cycles with sample_tick=1. Cycles without a tick hold all state.
  - tick_cnt: $clog2(OVERSAMPLE) bits.
  - bit_cnt: $clog2(WIDTH)+1 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_busy=0.
  - On a tick with rx_s=0: go to START, tick_cnt=0, rx_busy=1 next cycle.
- START:
  - Each tick, tick_cnt++.
  - At the tick where tick_cnt==OVERSAMPLE/2-1, sample the bit:
    - Sample=1 (false start/glitch): return to IDLE, no rx_valid, no error flags changed.
    - Sample=0: go to DATA with tick_cnt=0, bit_cnt=0.
- DATA:
  - Each tick, tick_cnt++.
  - At tick_cnt==OVERSAMPLE-1 (bit centre): shift the sample into the shift register MSB (shift right), tick_cnt=0, bit_cnt++.
  - When bit_cnt==WIDTH-1 at a sample: go to PARITY.
  - After WIDTH samples the first bit received sits in bit 0.
- PARITY: same centre timing; latch the parity sample, then go to STOP.
- STOP: at the centre tick:
  - rx_data <= shift register.
  - parity_err <= ((^shift) ^ parity_even_n) != parity sample.
  - frame_err <= (stop sample == 0).
  - Next cycle: rx_valid=1 for exactly one clk, rx_busy=0, state=IDLE.
- After a frame error with the line still low, IDLE treats the line as a new start bit. This is required behaviour; break detection is not provided.
- rx_valid has no backpressure. A new frame overwrites rx_data; the consumer must capture it on the pulse.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values. No rx_valid is issued for that frame.
- A sample_tick in the same cycle as rst_n=0: reset wins.
- Latency: rx_valid rises 1 clk after the STOP centre tick, which is about half a bit period after the stop-bit start edge. Add 2 clk for the synchroniser.
- parity_even_n is sampled at the STOP decision; it must be stable throughout the frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit decision (start, data, parity, stop) is the 2-of-3 majority of rx_s captured at the decision tick and the two ticks before it (tick_cnt = D-2, D-1, D, where D is the decision count).
  - Single-tick glitches at a bit centre are rejected.
  - The false-start check also uses the majority.
- Undefined: a single rx_s sample at the decision tick. No extra sample flops.

Test Plan:
- Even parity (parity_even_n=0): send 0xA5A5_5A5A, parity 0, stop 1 with OVERSAMPLE=16 -> one rx_valid pulse, rx_data=0xA5A5_5A5A, parity_err=0, frame_err=0, rx_busy high for the whole frame.
- Odd parity: parity_even_n=1, send 0x0000_0001 with parity bit 0 -> rx_data=0x0000_0001, parity_err=0. Resend with parity bit 1 -> parity_err=1, data still 0x0000_0001.
- Framing error: send 0xFFFF_FFFF with stop bit driven 0 -> rx_valid pulse, frame_err=1. After the line returns high for 1 bit, a clean frame 0x1234_5678 -> frame_err=0.
- False start: drive rx_line low for 3 ticks, then high -> FSM back in IDLE, rx_valid never asserted, rx_busy drops within OVERSAMPLE/2 ticks.
- Reset mid-frame: assert rst_n=0 for 1 clk after 10 data bits of 0xDEAD_BEEF -> all outputs 0, no rx_valid. A following full frame 0xCAFE_F00D is received correctly.
- With UART_RX_MAJORITY_EN: inject a 1-tick inverted glitch at the centre of data bit 5 of 0x0000_0000 -> rx_data=0x0000_0000. Without the macro, the same stimulus -> rx_data=0x0000_0020.
